// File: rtl/tx_logic_2.sv
// tx_logic_2: transmit-side flit distributor.
// Drains a show-ahead output FIFO and pushes each flit to one of five port
// channels with a level req/ack handshake. The destination port comes from
// the low three bits of the flit. Port values 5..7 are counted as drops and
// never raise a request. Flits are always delivered in FIFO order.
module tx_logic_2 #(
    parameter int SIZE   = 8,
    parameter int DROP_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fifo_empty,
    input  logic [SIZE-1:0]     fifo_data_out,
    output logic                fifo_read,
    output logic [4:0]          push_req,
    input  logic [4:0]          push_ack,
    output logic [SIZE*5-1:0]   push_data,
    output logic                busy,
    output logic [DROP_W-1:0]   drop_count
);

    localparam int NUM_PORTS = 5;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     flit_q, flit_d;
    logic [2:0]          sel_q, sel_d;
    logic [4:0]          req_q, req_d;
    logic                busy_q, busy_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic                ackSel;
    logic [2:0]          popSel;
    logic                popValid;
    logic [4:0]          popReq;
    logic [DROP_W-1:0]   dropInc;

    // Pick out the acknowledge of the port we are currently driving; acks on
    // any other port must not complete the transfer.
    always_comb begin
        ackSel = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (sel_q == 3'(p)) begin
                ackSel = push_ack[p];
            end
        end
    end

    // Decode the head flit's port field into a one-hot request, empty when
    // the field names a port that does not exist.
    always_comb begin
        popSel   = fifo_data_out[2:0];
        popValid = (popSel < 3'(NUM_PORTS));
        popReq   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            popReq[p] = popValid && (popSel == 3'(p));
        end
    end

    // The drop counter sticks at all-ones instead of wrapping.
    always_comb begin
        if (drop_q == {DROP_W{1'b1}}) begin
            dropInc = drop_q;
        end else begin
            dropInc = drop_q + DROP_W'(1);
        end
    end

    // Pop the FIFO whenever nothing is held, or the held flit is being
    // accepted this edge, so back-to-back flits stream at one per cycle.
    always_comb begin
        fifo_read = !reset && !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == SEND) && ackSel));
    end

    // Next-state logic: load the head flit on every pop, otherwise hold the
    // current request until its own port acknowledges it.
    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        sel_d   = sel_q;
        req_d   = req_q;
        busy_d  = busy_q;
        drop_d  = drop_q;

        if (fifo_read) begin
            flit_d = fifo_data_out;
            sel_d  = popSel;
            if (popValid) begin
                state_d = SEND;
                req_d   = popReq;
                busy_d  = 1'b1;
            end else begin
                state_d = IDLE;
                req_d   = '0;
                busy_d  = 1'b0;
                drop_d  = dropInc;
            end
        end else if ((state_q == SEND) && ackSel) begin
            state_d = IDLE;
            req_d   = '0;
            busy_d  = 1'b0;
        end
    end

    // State and registered outputs; reset discards any held flit outright.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            flit_q  <= '0;
            sel_q   <= '0;
            req_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    // Each port slice carries the held flit only while that port is
    // requested, so every unselected slice reads as zero.
    always_comb begin
        push_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_q[p]) begin
                push_data[SIZE*p +: SIZE] = flit_q;
            end
        end
    end

    assign push_req   = req_q;
    assign busy       = busy_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_tx_logic_2.sv
// Testbench for tx_logic_2: directed scenarios followed by random traffic,
// all checked cycle by cycle against a held-flit reference model plus an
// in-order delivery scoreboard.
module tb_tx_logic_2;

    localparam int SIZE   = 8;
    localparam int DROP_W = 2;
    localparam int NP     = 5;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 fifo_empty;
    logic [SIZE-1:0]      fifo_data_out;
    logic                 fifo_read;
    logic [4:0]           push_req;
    logic [4:0]           push_ack;
    logic [SIZE*NP-1:0]   push_data;
    logic                 busy;
    logic [DROP_W-1:0]    drop_count;

    tx_logic_2 #(.SIZE(SIZE), .DROP_W(DROP_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_read     (fifo_read),
        .push_req      (push_req),
        .push_ack      (push_ack),
        .push_data     (push_data),
        .busy          (busy),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [SIZE-1:0] fifoQ[$];
    logic [SIZE-1:0] acceptedQ[$];
    bit              heldValid = 1'b0;
    logic [SIZE-1:0] heldFlit  = '0;
    int              dropModel = 0;
    int              readPulses = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveFifo();
        fifo_empty    = (fifoQ.size() == 0);
        fifo_data_out = (fifoQ.size() == 0) ? '0 : fifoQ[0];
    endtask

    task automatic applyStimulus(input logic resetVal, input logic [4:0] ackVal);
        reset    = resetVal;
        push_ack = ackVal;
        driveFifo();
    endtask

    // One clock: compare DUT outputs at the falling edge, advance the model
    // for the coming rising edge, then update the FIFO lines after it.
    task automatic stepCycle();
        logic [4:0]         expReq;
        logic [SIZE*NP-1:0] expData;
        bit                 expRead;
        int                 port;
        logic [SIZE-1:0]    f;
        @(negedge clk);
        port    = int'(heldFlit[2:0]);
        expReq  = '0;
        expData = '0;
        if (heldValid) begin
            expReq[port] = 1'b1;
            expData[SIZE*port +: SIZE] = heldFlit;
        end
        expRead = !reset && (fifoQ.size() > 0) && (!heldValid || push_ack[port]);
        checkOutput("fifo_read", 64'(fifo_read), 64'(expRead));
        checkOutput("push_req", 64'(push_req), 64'(expReq));
        checkOutput("push_data", 64'(push_data), 64'(expData));
        checkOutput("busy", 64'(busy), 64'(heldValid));
        checkOutput("drop_count", 64'(drop_count), 64'(dropModel));
        if (fifo_read) readPulses++;

        if (reset) begin
            heldValid = 1'b0;
            heldFlit  = '0;
            dropModel = 0;
            acceptedQ.delete();
        end else begin
            if (heldValid && push_ack[port]) begin
                if (acceptedQ.size() > 0) begin
                    checkOutput("delivery", 64'(push_data[SIZE*port +: SIZE]),
                                64'(acceptedQ.pop_front()));
                end
                heldValid = 1'b0;
            end
            if (expRead) begin
                f = fifoQ.pop_front();
                heldFlit = f;
                if (f[2:0] < 3'd5) begin
                    heldValid = 1'b1;
                    acceptedQ.push_back(f);
                end else begin
                    heldValid = 1'b0;
                    if (dropModel < DROP_MAX) dropModel++;
                end
            end
        end
        @(posedge clk);
        #1;
        driveFifo();
    endtask

    initial begin
        int startPulses;
        applyStimulus(1'b1, 5'b00000);
        @(posedge clk);
        #1;

        // Reset then idle
        stepCycle();
        stepCycle();
        checkOutput("resetReq", 64'(push_req), 64'h0);
        checkOutput("resetDrop", 64'(drop_count), 64'h0);
        applyStimulus(1'b0, 5'b00000);
        stepCycle();

        // Single flit to port 2, acked after three request cycles
        startPulses = readPulses;
        fifoQ.push_back(8'hA2);
        applyStimulus(1'b0, 5'b00000);
        stepCycle();
        checkOutput("singleReq", 64'(push_req), 64'h04);
        checkOutput("singleData", 64'(push_data[23:16]), 64'hA2);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 5'b00100);
        stepCycle();
        applyStimulus(1'b0, 5'b00000);
        checkOutput("singleReqDone", 64'(push_req), 64'h0);
        stepCycle();
        checkOutput("singlePops", 64'(readPulses - startPulses), 64'd1);

        // Back-to-back with ack held high on every port
        startPulses = readPulses;
        fifoQ.push_back(8'h01);
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h04);
        applyStimulus(1'b0, 5'b11111);
        stepCycle();
        checkOutput("b2bReq0", 64'(push_req), 64'h02);
        stepCycle();
        checkOutput("b2bReq1", 64'(push_req), 64'h02);
        stepCycle();
        checkOutput("b2bReq2", 64'(push_req), 64'h10);
        stepCycle();
        stepCycle();
        checkOutput("b2bPops", 64'(readPulses - startPulses), 64'd3);
        checkOutput("b2bDrop", 64'(drop_count), 64'd0);

        // Invalid port followed by a valid flit, then drop saturation
        fifoQ.push_back(8'h07);
        fifoQ.push_back(8'h13);
        applyStimulus(1'b0, 5'b00000);
        stepCycle();
        checkOutput("invDrop", 64'(drop_count), 64'd1);
        checkOutput("invNoReq", 64'(push_req), 64'h0);
        stepCycle();
        checkOutput("invReq", 64'(push_req), 64'h08);
        checkOutput("invData", 64'(push_data[31:24]), 64'h13);
        applyStimulus(1'b0, 5'b01000);
        stepCycle();
        for (int i = 0; i < 5; i++) fifoQ.push_back(8'h05 + 8'(i % 3));
        applyStimulus(1'b0, 5'b00000);
        for (int i = 0; i < 6; i++) stepCycle();
        checkOutput("dropSat", 64'(drop_count), 64'd3);

        // Acks on the wrong port must neither complete nor pop
        startPulses = readPulses;
        fifoQ.push_back(8'h09);
        fifoQ.push_back(8'h2C);
        applyStimulus(1'b0, 5'b00100);
        for (int i = 0; i < 5; i++) stepCycle();
        checkOutput("wrongAckHold", 64'(push_req), 64'h02);
        checkOutput("wrongAckPops", 64'(readPulses - startPulses), 64'd1);
        applyStimulus(1'b0, 5'b00010);
        stepCycle();
        applyStimulus(1'b0, 5'b10000);
        stepCycle();
        stepCycle();

        // Reset while a flit to port 0 is pending
        fifoQ.push_back(8'h20);
        fifoQ.push_back(8'h42);
        applyStimulus(1'b0, 5'b00000);
        stepCycle();
        stepCycle();
        applyStimulus(1'b1, 5'b00000);
        stepCycle();
        checkOutput("rstReq", 64'(push_req), 64'h0);
        checkOutput("rstHead", 64'(fifo_data_out), 64'h42);
        applyStimulus(1'b0, 5'b00100);
        stepCycle();
        stepCycle();
        stepCycle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] ack;
            if (fifoQ.size() < 8 && $urandom_range(0, 1) == 1)
                fifoQ.push_back(SIZE'($urandom_range(0, 255)));
            ack = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom);
            applyStimulus(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, ack);
            stepCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/tx_logic_2.md
Name: tx_logic_2

Overview:
- Transmit-side counterpart of the router input arbiter. It drains flits from a local output FIFO and delivers each one to one of 5 port channels using the same level req/ack push handshake the input side consumes.
- The destination port is taken from the flit's low bits. Each port has its own data slice, matching the packed 5-port bus format.
- Sits between an output-queue FIFO and the downstream port inputs.

Parameters:
- SIZE, 8, flit width in bits. Must be ≥ 3.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fifo_empty  input  1  FIFO has no flit.
- fifo_data_out  input  SIZE  head flit. Show-ahead: valid whenever fifo_empty=0.
- fifo_read  output  1  pop strobe; FIFO advances at this clock edge.
- push_req  output  5  per-port request, one-hot or zero.
- push_ack  input  5  per-port acknowledge.
- push_data  output  SIZE*5  port p uses bits [SIZE*p +: SIZE].
- busy  output  1  a flit is held awaiting ack.
- drop_count  output  DROP_W  count of flits with an invalid port field, saturating.

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, and overrides everything on the same edge.
- Reset values: state=IDLE, push_req=0, push_data=0, busy=0, drop_count=0, held flit register=0.
- Port field: sel = flit[2:0]. Values 0..4 are valid. Values 5..7 are invalid.
- fifo_read is combinational: fifo_read = !reset && !fifo_empty && (state==IDLE || (state==SEND && push_ack[sel_q])). Never asserted when fifo_empty=1.
- IDLE, fifo_empty=1: stay in IDLE. Outputs are 0.
- IDLE, fifo_empty=0: pop the flit and latch it into flit_q/sel_q.
  - Valid sel: go to SEND. Next cycle push_req[sel]=1, push_data slice sel=flit, all other slices 0, busy=1.
  - Invalid sel: stay in IDLE and increment drop_count, saturating at all-ones. No req is raised.
- SEND: hold push_req, push_data and flit_q stable until push_ack[sel_q]=1. Acks on non-selected ports are ignored.
- Transfer completes on the edge where push_req[sel_q]=1 and push_ack[sel_q]=1.
- Completion, FIFO empty: go to IDLE. push_req=0, push_data=0, busy=0 next cycle.
- Completion, FIFO non-empty (back-to-back): pop the next flit in the same cycle.
  - Valid sel: stay in SEND with the new req/data next cycle. Same port: req stays high. Different port: old bit drops and new bit rises on the same edge.
  - Invalid sel: count a drop and go to IDLE.
- Latency: fifo non-empty in IDLE at cycle t → push_req high at t+1. Sustained throughput is 1 flit/cycle when ack is held high.
- push_req has at most one bit set in any cycle. push_data is 0 in every unselected slice.
- Reset mid-SEND: the held flit is discarded, not re-queued. The FIFO is not popped in the reset cycle.
- fifo_data_out is sampled only on edges where fifo_read=1.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with fifo_empty=1 → all outputs 0; fifo_read=0 throughout.
- Single flit: flit 8'hA2 (port 2), ack after 3 cycles → push_req=5'b00100 and push_data[23:16]=8'hA2 from t+1 until the ack edge; push_req=0 the cycle after; exactly one fifo_read pulse.
- Back-to-back: flits 8'h01, 8'h11, 8'h04 queued, push_ack=5'b11111 constant → push_req sequence 00010, 00010, 10000 on consecutive cycles; 3 fifo_read pulses; drop_count=0.
- Invalid port: flits 8'h07 then 8'h13 → drop_count=1, no req for 8'h07, then push_req=5'b01000 with data 8'h13. With DROP_W=2 and 5 invalid flits → drop_count saturates at 3.
- Wrong-port ack: flit to port 1, push_ack=5'b00100 for 4 cycles → req held and no pop; then push_ack=5'b00010 → transfer completes.
- Reset during SEND: flit to port 0 pending, reset pulsed → push_req=0 the next cycle; the flit is never delivered; the FIFO head is unchanged by the reset cycle.
